// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes, master bridge state encoding
// and the response error classifier.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } axil_mst_state_t;

  // EXOKAY counts as success; only SLVERR and DECERR report an error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axil_master_bridge.sv
// Single-outstanding CPU load/store to AXI-Lite master bridge with a local
// address-window check and a buffered response stage.
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] WIN_BASE   = 32'h2000_0000,
  parameter logic [ADDR_WIDTH-1:0] WIN_MASK   = 32'hFFFF_F000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [3:0]            req_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  axil_mst_state_t       state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  in_win;

  assign in_win = (req_addr_i & WIN_MASK) == WIN_BASE;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (!in_win) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RSP;
          end else if (req_we_i) begin
            addr_d    = req_addr_i;
            wdata_d   = req_wdata_i;
            wstrb_d   = req_wstrb_i;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            addr_d    = req_addr_i;
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR: begin
        // A dropped valid doubles as the per-channel "done" flag.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          err_d   = resp_is_err(m_axi_bresp);
          rdata_d = '0;
          state_d = RSP;
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          err_d   = resp_is_err(m_axi_rresp);
          rdata_d = resp_is_err(m_axi_rresp) ? '0 : m_axi_rdata;
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RSP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (state_q == WR_RESP);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = (state_q == RD_DATA);

endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: a delay-programmable AXI-Lite memory slave
// plus a transaction-level reference model of responses and latency.
module tb_axil_master_bridge;

  localparam logic [31:0] WIN_BASE = 32'h2000_0000;
  localparam logic [31:0] WIN_MASK = 32'hFFFF_F000;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_wstrb;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  axil_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WIN_BASE(WIN_BASE), .WIN_MASK(WIN_MASK)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave knobs: per-channel ready/response delays and response codes.
  int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
  logic [1:0]  b_resp_k, r_resp_k;
  logic        r_ovr;
  logic [31:0] r_ovr_data;

  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        wa_have, wd_have, r_pend;
  logic [31:0] wa_addr, wd_data, ra_addr;
  logic [3:0]  wd_strb;
  logic [31:0] smem [16];

  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid  && (w_cnt  >= w_delay);
  assign arready = arvalid && (ar_cnt >= ar_delay);

  always @(posedge clk) begin : slave_wr
    logic        a_now, d_now;
    logic [31:0] a_addr, d_data, merged;
    logic [3:0]  d_strb;
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      wa_have <= 1'b0; wd_have <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      wa_addr <= '0; wd_data <= '0; wd_strb <= '0;
      for (int i = 0; i < 16; i++) smem[i] <= '0;
    end else begin
      a_now  = wa_have || (awvalid && awready);
      a_addr = wa_have ? wa_addr : awaddr;
      d_now  = wd_have || (wvalid && wready);
      d_data = wd_have ? wd_data : wdata;
      d_strb = wd_have ? wd_strb : wstrb;
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (awvalid && awready) begin wa_have <= 1'b1; wa_addr <= awaddr; end
      if (wvalid && wready) begin wd_have <= 1'b1; wd_data <= wdata; wd_strb <= wstrb; end
      if (bvalid && bready) bvalid <= 1'b0;
      if (a_now && d_now && !bvalid) begin
        if (b_cnt >= b_delay) begin
          bvalid <= 1'b1; bresp <= b_resp_k; b_cnt <= 0;
          wa_have <= 1'b0; wd_have <= 1'b0;
          if (!b_resp_k[1]) begin
            merged = smem[a_addr[5:2]];
            for (int b = 0; b < 4; b++) if (d_strb[b]) merged[8*b +: 8] = d_data[8*b +: 8];
            smem[a_addr[5:2]] <= merged;
          end
        end else begin
          b_cnt <= b_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk) begin : slave_rd
    logic        r_now;
    logic [31:0] r_a;
    if (rst) begin
      ar_cnt <= 0; r_cnt <= 0; r_pend <= 1'b0; ra_addr <= '0;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
    end else begin
      r_now = r_pend || (arvalid && arready);
      r_a   = r_pend ? ra_addr : araddr;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (arvalid && arready) begin r_pend <= 1'b1; ra_addr <= araddr; end
      if (rvalid && rready) rvalid <= 1'b0;
      if (r_now && !rvalid) begin
        if (r_cnt >= r_delay) begin
          rvalid <= 1'b1; rresp <= r_resp_k; r_pend <= 1'b0; r_cnt <= 0;
          rdata  <= r_ovr ? r_ovr_data : smem[r_a[5:2]];
        end else begin
          r_cnt <= r_cnt + 1;
        end
      end
    end
  end

  // Bus monitor: handshake/valid-cycle counters and valid-hold/stability rule.
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs, vld_cyc, awv_cyc, wv_cyc, prot_viol;
  logic        p_ok, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awa, p_wd, p_ara;
  logic [3:0]  p_ws;

  initial begin
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    vld_cyc = 0; awv_cyc = 0; wv_cyc = 0; prot_viol = 0; p_ok = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      p_ok = 1'b0;
    end else begin
      if (p_ok) begin
        if (p_awv && !p_awr && !(awvalid && awaddr == p_awa)) prot_viol++;
        if (p_wv && !p_wr && !(wvalid && wdata == p_wd && wstrb == p_ws)) prot_viol++;
        if (p_arv && !p_arr && !(arvalid && araddr == p_ara)) prot_viol++;
      end
      if (awvalid && awready) aw_hs++;
      if (wvalid && wready)   w_hs++;
      if (bvalid && bready)   b_hs++;
      if (arvalid && arready) ar_hs++;
      if (rvalid && rready)   r_hs++;
      if (awvalid || wvalid || arvalid) vld_cyc++;
      if (awvalid) awv_cyc++;
      if (wvalid)  wv_cyc++;
      p_awv = awvalid; p_awr = awready; p_awa = awaddr;
      p_wv  = wvalid;  p_wr  = wready;  p_wd  = wdata; p_ws = wstrb;
      p_arv = arvalid; p_arr = arready; p_ara = araddr;
      p_ok  = 1'b1;
    end
  end

  int          checks, errors;
  logic [31:0] ref_mem [16];
  int          s_aw, s_w, s_b, s_ar, s_r, s_vld, s_awv, s_wv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, compare the response against the reference model.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] strb, input int hold);
    logic        in_win, e_err;
    logic [31:0] e_rd, merged;
    logic [19:0] e_hs;
    int          e_lat, lat, n;
    in_win = (addr & WIN_MASK) == WIN_BASE;
    if (!in_win) begin
      e_err = 1'b1; e_rd = '0; e_lat = 1; e_hs = '0;
    end else if (we) begin
      e_err = b_resp_k[1]; e_rd = '0;
      e_lat = 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay;
      e_hs  = {4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
      if (!e_err) begin
        merged = ref_mem[addr[5:2]];
        for (int b = 0; b < 4; b++) if (strb[b]) merged[8*b +: 8] = wd[8*b +: 8];
        ref_mem[addr[5:2]] = merged;
      end
    end else begin
      e_err = r_resp_k[1];
      e_rd  = e_err ? 32'h0 : (r_ovr ? r_ovr_data : ref_mem[addr[5:2]]);
      e_lat = 3 + ar_delay + r_delay;
      e_hs  = {4'd0, 4'd0, 4'd0, 4'd1, 4'd1};
    end
    s_aw = aw_hs; s_w = w_hs; s_b = b_hs; s_ar = ar_hs; s_r = r_hs;
    s_vld = vld_cyc; s_awv = awv_cyc; s_wv = wv_cyc;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = strb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    check({tag, ".lat"}, 64'(lat), 64'(e_lat));
    check({tag, ".err"}, 64'(rsp_err), 64'(e_err));
    check({tag, ".rdata"}, 64'(rsp_rdata), 64'(e_rd));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, ".hold"}, {30'd0, rsp_valid, req_ready, rsp_err, rsp_rdata},
            {30'd0, 1'b1, 1'b0, e_err, e_rd});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".hs"}, 64'({4'(aw_hs - s_aw), 4'(w_hs - s_w), 4'(b_hs - s_b),
                             4'(ar_hs - s_ar), 4'(r_hs - s_r)}), 64'(e_hs));
    if (!in_win) check({tag, ".novalid"}, 64'(vld_cyc - s_vld), 64'd0);
  endtask

  initial begin
    logic        rw;
    logic [31:0] ra;
    checks = 0; errors = 0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; rsp_ready = 1'b0;
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
    b_resp_k = 2'b00; r_resp_k = 2'b00; r_ovr = 1'b0; r_ovr_data = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset.ctrl", {57'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err}, 64'd0);
    check("reset.data", {rsp_rdata, awaddr | araddr | wdata | {28'd0, wstrb}}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset.req_ready", 64'(req_ready), 64'd1);

    txn("gpio_wr", 1'b1, WIN_BASE, 32'hA5A5_0F0F, 4'hF, 0);
    check("gpio_out", 64'(smem[0]), 64'h0000_0000_A5A5_0F0F);

    r_ovr = 1'b1; r_ovr_data = 32'h0000_1234;
    txn("gpio_rd", 1'b0, WIN_BASE, '0, '0, 0);
    r_ovr = 1'b0;

    aw_delay = 4;
    txn("stall_wr", 1'b1, WIN_BASE + 32'h4, 32'h1122_3344, 4'hF, 0);
    check("stall.awv_cycles", 64'(awv_cyc - s_awv), 64'd5);
    check("stall.wv_cycles", 64'(wv_cyc - s_wv), 64'd1);
    aw_delay = 0;

    txn("oow_rd", 1'b0, 32'h1000_0000, '0, '0, 0);

    r_resp_k = 2'b10; r_ovr = 1'b1; r_ovr_data = 32'hDEAD_BEEF;
    txn("slverr_rd", 1'b0, WIN_BASE + 32'h4, '0, '0, 5);
    r_resp_k = 2'b00; r_ovr = 1'b0;

    txn("edge_wr", 1'b1, WIN_BASE + 32'hFFC, 32'hCAFE_F00D, 4'b0101, 0);
    txn("edge_rd", 1'b0, WIN_BASE + 32'hFFC, '0, '0, 0);
    txn("oow_hi", 1'b1, WIN_BASE + 32'h1000, 32'h5555_5555, 4'hF, 0);
    txn("oow_lo", 1'b0, WIN_BASE - 32'h4, '0, '0, 0);
    b_resp_k = 2'b01;
    txn("exokay_wr", 1'b1, WIN_BASE + 32'h8, 32'h0BAD_F00D, 4'hF, 0);
    b_resp_k = 2'b11;
    txn("decerr_wr", 1'b1, WIN_BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, 0);
    b_resp_k = 2'b00;
    txn("rd_back", 1'b0, WIN_BASE + 32'h8, '0, '0, 0);
    txn("rd_stall", 1'b0, WIN_BASE + 32'h4, '0, '0, 0);

    for (int i = 0; i < 24; i++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      b_resp_k = 2'($urandom_range(0, 3)); r_resp_k = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        ra = $urandom;
        if ((ra & WIN_MASK) == WIN_BASE) ra = ra ^ 32'h8000_0000;
      end else begin
        ra = WIN_BASE | (32'($urandom_range(0, 1023)) << 2);
      end
      txn("rand", rw, ra, $urandom, 4'($urandom_range(0, 15)), 0);
    end
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
    b_resp_k = 2'b00; r_resp_k = 2'b00;

    aw_delay = 20;
    req_valid = 1'b1; req_we = 1'b1; req_addr = WIN_BASE + 32'hC;
    req_wdata = 32'h7777_8888; req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid.awvalid_before", 64'(awvalid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid.ctrl", {56'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err, req_ready}, 64'd1);
    check("rst_mid.addr", 64'(awaddr), 64'd0);
    rst = 1'b0;
    aw_delay = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    @(negedge clk);
    txn("post_rst_rd", 1'b0, WIN_BASE, '0, '0, 0);
    txn("post_rst_wr", 1'b1, WIN_BASE + 32'hC, 32'h1357_9BDF, 4'hF, 0);

    check("protocol_violations", 64'(prot_viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
